// File: rtl/quad_encoder_tx.sv
// rtl/quad_encoder_tx.sv - quadrature rotary-encoder transmitter
// Plays step commands out as enc_a/enc_b detent sequences with an optional button press.
module quad_encoder_tx #(
  parameter int PHASE_CYCLES = 2500,
  parameter int GAP_CYCLES   = 10000,
  parameter int PRESS_CYCLES = 250000,
  parameter int COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic               cmd_press,
  output logic               enc_a,
  output logic               enc_b,
  output logic               enc_btn,
  output logic               busy,
  output logic [COUNT_W-1:0] steps_done,
  output logic               done
);

  localparam int MAX_PG = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_PG > PRESS_CYCLES) ? MAX_PG : PRESS_CYCLES;
  localparam int TW     = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] PH_LOAD  = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] PR_LOAD  = TW'(PRESS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PHASE,
    S_GAP,
    S_PRESS,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [1:0]         phase_q, phase_d;
  logic               dir_q, dir_d;
  logic               press_q, press_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic [COUNT_W-1:0] steps_done_q, steps_done_d;
  logic               enc_a_q, enc_a_d;
  logic               enc_b_q, enc_b_d;
  logic               enc_btn_q, enc_btn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               accept;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    phase_d      = phase_q;
    dir_d        = dir_q;
    press_d      = press_q;
    rem_d        = rem_q;
    steps_done_d = steps_done_q;
    accept       = cmd_valid && cmd_ready_q && (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dir_d        = cmd_dir;
          press_d      = cmd_press;
          rem_d        = cmd_steps;
          steps_done_d = '0;
          phase_d      = 2'd0;
          if (cmd_steps != '0) begin
            state_d = S_PHASE;
            timer_d = PH_LOAD;
          end else if (cmd_press) begin
            state_d = S_PRESS;
            timer_d = PR_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PHASE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (phase_q != 2'd3) begin
          phase_d = phase_q + 2'd1;
          timer_d = PH_LOAD;
        end else begin
          // rem_q is checked before the decrement, so it bottoms out at zero
          steps_done_d = steps_done_q + COUNT_W'(1);
          rem_d        = rem_q - COUNT_W'(1);
          phase_d      = 2'd0;
          if (rem_q > COUNT_W'(1)) begin
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              timer_d = GAP_LOAD;
            end else begin
              timer_d = PH_LOAD;
            end
          end else if (press_q) begin
            state_d = S_PRESS;
            timer_d = PR_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = S_PHASE;
          phase_d = 2'd0;
          timer_d = PH_LOAD;
        end
      end
      S_PRESS: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the current state, so the waveform trails the FSM by one cycle
    enc_a_d   = 1'b0;
    enc_b_d   = 1'b0;
    if (state_q == S_PHASE) begin
      if (dir_q) begin
        enc_a_d = (phase_q == 2'd0) || (phase_q == 2'd1);
        enc_b_d = (phase_q == 2'd1) || (phase_q == 2'd2);
      end else begin
        enc_a_d = (phase_q == 2'd1) || (phase_q == 2'd2);
        enc_b_d = (phase_q == 2'd0) || (phase_q == 2'd1);
      end
    end
    enc_btn_d = (state_q == S_PRESS);
    done_d    = (state_q == S_DONE);

    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;
    if (accept) begin
      busy_d      = 1'b1;
      cmd_ready_d = 1'b0;
    end else if (done_q) begin
      busy_d      = 1'b0;
      cmd_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      phase_q      <= 2'd0;
      dir_q        <= 1'b0;
      press_q      <= 1'b0;
      rem_q        <= '0;
      steps_done_q <= '0;
      enc_a_q      <= 1'b0;
      enc_b_q      <= 1'b0;
      enc_btn_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      phase_q      <= phase_d;
      dir_q        <= dir_d;
      press_q      <= press_d;
      rem_q        <= rem_d;
      steps_done_q <= steps_done_d;
      enc_a_q      <= enc_a_d;
      enc_b_q      <= enc_b_d;
      enc_btn_q    <= enc_btn_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign enc_a      = enc_a_q;
  assign enc_b      = enc_b_q;
  assign enc_btn    = enc_btn_q;
  assign busy       = busy_q;
  assign steps_done = steps_done_q;
  assign done       = done_q;

endmodule
